instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction buffer entry count and the maximum number of in-flight requests.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_addr  out  32  fetch word address.
REQ-007 imem_req_ready  in  1  memory accepts the request.
REQ-008 imem_rsp_valid  in  1  response data valid; responses arrive in request order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  branch/jump/jalr taken; PC unit overrides the fetch stream.
REQ-011 redirect_pc  in  32  new fetch target.
REQ-012 if_valid  out  1  instruction available to the decoder.
REQ-013 if_instr  out  32  instruction word at the buffer head.
REQ-014 if_pc  out  32  address of if_instr.
REQ-015 if_ready  in  1  decoder consumes the head this cycle.
REQ-016 fetch_err  out  1  sticky protocol error flag.

Function
REQ-017 SHALL use FSM states FETCH and DRAIN: FETCH→DRAIN on redirect with an uncancelled in-flight count >0; DRAIN→FETCH once the discard count reaches 0.
REQ-018 SHALL keep fetch PC fpc, advance fpc by 4 (modulo 2^32, wrapping 32'hFFFF_FFFC→0) on every accepted request, and drive imem_req_addr = fpc.
REQ-019 SHALL assert imem_req_valid only in FETCH, without redirect_valid, when outstanding + buffer count < DEPTH, or = DEPTH with a pop this cycle.
REQ-020 SHALL hold imem_req_valid and imem_req_addr stable while imem_req_valid && !imem_req_ready, except when a redirect occurs.
REQ-021 SHALL record each accepted request address in an in-flight PC queue and pair it with the matching response.
REQ-022 SHALL push {pc, imem_rsp_data} into the buffer on a non-discarded response.
REQ-023 SHALL pop the buffer on if_valid && if_ready.
REQ-024 SHALL drive if_valid = buffer non-empty, with if_instr/if_pc taken from the head.
REQ-025 SHALL allow simultaneous push and pop; the credit rule of REQ-019 guarantees the buffer never overflows.
REQ-026 On redirect_valid, SHALL, in the same edge: flush the buffer; set fpc = {redirect_pc[31:2],2'b00}; add all in-flight requests not completing this cycle to the discard count; and drop any response arriving this cycle.
REQ-027 A redirect in DRAIN SHALL update fpc only; the discard count continues to decrement.
REQ-028 In DRAIN, each response SHALL decrement the discard count and SHALL never be pushed.
REQ-029 If redirect and pop occur in the same cycle, the flush SHALL win.
REQ-030 SHALL set fetch_err on imem_rsp_valid with zero outstanding; the response SHALL be ignored and fetch_err SHALL stay set until reset.
REQ-031 With zero-wait memory (ready=1, response 1 cycle after acceptance) and if_ready=1, SHALL deliver one instruction per cycle, with first if_valid 2 cycles after the first request acceptance.

Reset
REQ-032 SHALL, while rst=0: fpc=RESET_PC, state=FETCH, buffer empty, outstanding=0, discard=0, imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0.
REQ-033 SHALL drive imem_req_valid=1 with addr=RESET_PC in the first cycle after rst rises.
REQ-034 Reset mid-transaction SHALL abandon all in-flight requests; late responses after reset SHALL set fetch_err.

Structure
REQ-035 Package fetch_pkg SHALL hold the default RESET_PC, the default DEPTH, the fetch_state_t enum (FETCH, DRAIN) and the buffer entry struct {pc, instr}.
REQ-036 The buffer SHALL be sub-module fetch_fifo (parameterised depth, push/pop/flush, count output), reused for the in-flight PC queue.

Verification
REQ-037 Reset release, zero-wait memory returning 32'h0000_0013 at every address, if_ready=1 -> if_pc sequence 0,4,8,12 on consecutive cycles, imem_req_valid first cycle.
REQ-038 if_ready=0 for 5 cycles -> at most 2 requests accepted, if_valid held with if_pc=0, no data loss when if_ready returns.
REQ-039 2 in flight, redirect_pc=32'h0000_0103 -> next request address 32'h100, two stale responses dropped, state DRAIN for their duration, first if_pc=32'h100.
REQ-040 imem_req_ready=0 for 3 cycles -> imem_req_addr held constant; redirect in that window changes addr the following cycle.
REQ-041 imem_rsp_valid pulse with nothing outstanding -> fetch_err=1, if_valid unchanged, fetch_err stays set until rst=0.
REQ-042 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction fetch unit and its buffers.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH    = 2;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with flush and occupancy count; used both as the
// instruction buffer and as the queue of in-flight request addresses.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Storage carries no reset; the count alone says which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= nextPtr(wr_q);
      if (do_pop)  rd_q <= nextPtr(rd_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction fetch: issues sequential word fetches, buffers
// in-order responses for the decoder and drains stale responses after a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_err
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          fetch_err_q;
  logic [CW-1:0] outstanding, buf_count;
  logic [CW:0]   credits_used;
  logic [31:0]   rsp_pc;
  fetch_entry_t  push_entry, head_entry;
  logic          req_fire, rsp_ok, rsp_keep, buf_pop;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every issued request owns a buffer slot, so the buffer can never overflow.
  assign credits_used   = {1'b0, outstanding} + {1'b0, buf_count};
  assign if_valid       = (buf_count != '0);
  assign buf_pop        = if_valid && if_ready && !redirect_valid;
  assign imem_req_valid = rst && (state_q == FETCH) && !redirect_valid &&
                          ((credits_used < DEPTH_W) || ((credits_used == DEPTH_W) && buf_pop));
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep       = rsp_ok && (state_q == FETCH) && !redirect_valid;
  assign push_entry     = '{pc: rsp_pc, instr: imem_rsp_data};
  assign if_instr       = if_valid ? head_entry.instr : '0;
  assign if_pc          = if_valid ? head_entry.pc : '0;
  assign fetch_err      = fetch_err_q;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_queue (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (req_fire),
    .pop_i   (rsp_ok),
    .flush_i (1'b0),
    .data_i  (fpc_q),
    .data_o  (rsp_pc),
    .count_o (outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_buffer (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (rsp_keep),
    .pop_i   (buf_pop),
    .flush_i (redirect_valid),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .count_o (buf_count)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    fpc_d     = fpc_q;
    if (redirect_valid) begin
      fpc_d = {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      fpc_d = fpc_q + 32'd4;
    end
    if (state_q == DRAIN) begin
      if (rsp_ok) discard_d = discard_q - CW'(1);
      if (discard_d == '0) state_d = FETCH;
    end else if (redirect_valid) begin
      discard_d = outstanding - CW'(rsp_ok);
      if (discard_d != '0) state_d = DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      fpc_q       <= RESET_PC;
      discard_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      discard_q <= discard_d;
      if (imem_rsp_valid && (outstanding == '0)) fetch_err_q <= 1'b1;
    end
  end

endmodule
